// File: rtl/freq_gate_ctrl_pkg.sv
// Shared types and constants for the equal-precision frequency meter gate controller.
package freq_gate_ctrl_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARM,
    GATE,
    SETTLE,
    LATCH
  } state_t;

  // Increment that sticks at lim so a long gate never wraps the length counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                input logic [CNT_W-1:0] lim);
    return (value >= lim) ? lim : value + 1'b1;
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Host/counter-side bundle of the gate controller; master = controller, slave = surroundings.
// ERR exists only when FREQ_GATE_TIMEOUT_EN is defined.
interface freq_gate_if;
  import freq_gate_ctrl_pkg::*;

  logic             START;
  logic             SIG;
  logic [CNT_W-1:0] Q_IN;
  logic [CNT_W-1:0] QBASE_IN;
  logic             CNT_CLR;
  logic             SIG_EN;
  logic             BASE_EN;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] SIG_CNT;
  logic [CNT_W-1:0] BASE_CNT;
`ifdef FREQ_GATE_TIMEOUT_EN
  logic             ERR;
`endif

  modport master (
    input  START, SIG, Q_IN, QBASE_IN,
`ifdef FREQ_GATE_TIMEOUT_EN
    output ERR,
`endif
    output CNT_CLR, SIG_EN, BASE_EN, BUSY, DONE, SIG_CNT, BASE_CNT
  );

  modport slave (
    output START, SIG, Q_IN, QBASE_IN,
`ifdef FREQ_GATE_TIMEOUT_EN
    input  ERR,
`endif
    input  CNT_CLR, SIG_EN, BASE_EN, BUSY, DONE, SIG_CNT, BASE_CNT
  );

endinterface

// File: rtl/freq_gate_ctrl_sig_edge_sync.sv
// Multi-FF synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
module sig_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_sig,
  output logic rise
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], async_sig};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign rise = sync_reg[STAGES-1] & ~prev_reg;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate controller for the equal-precision frequency meter: signal-aligned gate, clear, settle, latch.
// Optional watchdog on ARM/GATE with ERR flag when FREQ_GATE_TIMEOUT_EN is defined.
module freq_gate_ctrl
  import freq_gate_ctrl_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 100000,
  parameter int unsigned CLR_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 4
`ifdef FREQ_GATE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
`endif
) (
  input logic         CLK,
  input logic         CLR,
  freq_gate_if.master bus
);

  localparam logic [CNT_W-1:0] GATE_LIM    = CNT_W'(GATE_CYCLES);
  localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef FREQ_GATE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t           state_reg;
  logic             cnt_clr_reg;
  logic             en_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CNT_W-1:0] sig_cnt_reg;
  logic [CNT_W-1:0] base_cnt_reg;
  logic [CNT_W-1:0] phase_cnt_reg;
  logic [CNT_W-1:0] gate_cnt_reg;
  logic             sig_rise;
`ifdef FREQ_GATE_TIMEOUT_EN
  logic [CNT_W-1:0] wdog_reg;
  logic             err_reg;
`endif

  sig_edge_sync #(
    .STAGES (2)
  ) u_sig_sync (
    .clk       (CLK),
    .rst_n     (CLR),
    .async_sig (bus.SIG),
    .rise      (sig_rise)
  );

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_reg     <= IDLE;
      cnt_clr_reg   <= 1'b0;
      en_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      sig_cnt_reg   <= '0;
      base_cnt_reg  <= '0;
      phase_cnt_reg <= '0;
      gate_cnt_reg  <= '0;
`ifdef FREQ_GATE_TIMEOUT_EN
      wdog_reg      <= '0;
      err_reg       <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_clr_reg <= 1'b1;
          if (bus.START) begin
            state_reg     <= CLEAR;
            cnt_clr_reg   <= 1'b0;
            busy_reg      <= 1'b1;
            phase_cnt_reg <= '0;
`ifdef FREQ_GATE_TIMEOUT_EN
            err_reg       <= 1'b0;
`endif
          end
        end
        CLEAR: begin
          if (phase_cnt_reg == CLR_LAST) begin
            state_reg   <= ARM;
            cnt_clr_reg <= 1'b1;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        ARM: begin
          // Opening on a synchronized edge keeps the signal count an integer number of periods.
          if (sig_rise) begin
            state_reg    <= GATE;
            gate_cnt_reg <= CNT_W'(1);
            en_reg       <= 1'b1;
          end
        end
        GATE: begin
          gate_cnt_reg <= sat_inc(gate_cnt_reg, GATE_LIM);
          if (sig_rise && (gate_cnt_reg >= GATE_LIM)) begin
            state_reg     <= SETTLE;
            en_reg        <= 1'b0;
            phase_cnt_reg <= '0;
          end
        end
        SETTLE: begin
          // Give the signal-domain counter time to settle before sampling Q_IN.
          if (phase_cnt_reg == SETTLE_LAST) begin
            state_reg    <= LATCH;
            sig_cnt_reg  <= bus.Q_IN;
            base_cnt_reg <= bus.QBASE_IN;
            done_reg     <= 1'b1;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        LATCH: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          en_reg    <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
`ifdef FREQ_GATE_TIMEOUT_EN
      // Watchdog overrides the state update above; results stay untouched.
      if (state_reg == ARM || state_reg == GATE) begin
        if (wdog_reg == TMO_LAST) begin
          state_reg   <= IDLE;
          en_reg      <= 1'b0;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b1;
          err_reg     <= 1'b1;
          cnt_clr_reg <= 1'b1;
        end else begin
          wdog_reg <= wdog_reg + 1'b1;
        end
      end else begin
        wdog_reg <= '0;
      end
`endif
    end
  end

  assign bus.CNT_CLR  = cnt_clr_reg;
  assign bus.SIG_EN   = en_reg;
  assign bus.BASE_EN  = en_reg;
  assign bus.BUSY     = busy_reg;
  assign bus.DONE     = done_reg;
  assign bus.SIG_CNT  = sig_cnt_reg;
  assign bus.BASE_CNT = base_cnt_reg;
`ifdef FREQ_GATE_TIMEOUT_EN
  assign bus.ERR      = err_reg;
`endif

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: counter-pair emulation, vector table, random periods vs ceil-based model.
// Timeout sequence is exercised when FREQ_GATE_TIMEOUT_EN is defined.
module tb_freq_gate_ctrl;

  localparam int G    = 100;
  localparam int CLRC = 2;
  localparam int SETC = 4;
  localparam int TMO  = 1000;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   period = 0;

  logic [31:0] q_model = '0;
  logic [31:0] base_model = '0;
  logic        sig_last = 1'b0;

  freq_gate_if bus();

  freq_gate_ctrl #(
    .GATE_CYCLES   (G),
    .CLR_CYCLES    (CLRC),
    .SETTLE_CYCLES (SETC)
`ifdef FREQ_GATE_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Emulated counter pair: signal counter counts SIG rises, base counter counts CLK, both cleared by CNT_CLR.
  always @(posedge CLK) begin
    sig_last <= bus.SIG;
    if (!bus.CNT_CLR) begin
      q_model    <= '0;
      base_model <= '0;
    end else begin
      if (bus.SIG_EN && bus.SIG && !sig_last) q_model <= q_model + 1;
      if (bus.BASE_EN) base_model <= base_model + 1;
    end
  end
  assign bus.Q_IN     = q_model;
  assign bus.QBASE_IN = base_model;

  // Free-running measured signal, 50% duty; period 0 holds it low.
  initial begin
    bus.SIG = 1'b0;
    forever begin
      if (period == 0) begin
        bus.SIG = 1'b0;
        @(negedge CLK);
      end else begin
        int p;
        p = period;
        bus.SIG = 1'b1;
        repeat (p / 2) @(negedge CLK);
        bus.SIG = 1'b0;
        repeat (p - p / 2) @(negedge CLK);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int n_periods(input int p);
    return (G + p - 1) / p;
  endfunction

  // One measurement: START pulse, observe enables until DONE, then confirm the controller stays idle.
  task automatic run_meas(input int p, input bit poke, output logic [31:0] s,
                          output logic [31:0] b, output int en_cyc);
    int  mism;
    int  dones;
    int  extra;
    bit  poked;
    bit  got;
    period = p;
    repeat (250 + $urandom_range(0, p)) @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    en_cyc = 0; mism = 0; dones = 0; extra = 0; poked = 1'b0; got = 1'b0;
    s = '0; b = '0;
    for (int k = 0; k < 2000 && !got; k++) begin
      bus.START = 1'b0;
      if (bus.SIG_EN !== bus.BASE_EN) mism++;
      if (bus.SIG_EN === 1'b1) en_cyc++;
      if (poke && !poked && en_cyc == 5) begin
        bus.START = 1'b1;
        poked = 1'b1;
      end
      if (bus.DONE === 1'b1) begin
        got = 1'b1;
        dones++;
        s = bus.SIG_CNT;
        b = bus.BASE_CNT;
        check("busy_at_done", 32'(bus.BUSY), 32'd1);
      end else begin
        @(negedge CLK);
      end
    end
    check("done_seen", 32'(got), 32'd1);
    check("en_pair", 32'(mism), 32'd0);
    @(negedge CLK);
    check("busy_falls_with_done", {30'd0, bus.BUSY, bus.DONE}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) extra++;
      @(negedge CLK);
    end
    check("no_restart", 32'(extra), 32'd0);
    $display("meas period=%0d poke=%0d sig_cnt=%0d base_cnt=%0d en_cycles=%0d", p, poke, s, b, en_cyc);
  endtask

  typedef struct {
    int          period;
    bit          poke;
    logic [31:0] exp_sig;
    logic [31:0] exp_base;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] s, b;
    logic [31:0] last_s, last_b;
    int          en_cyc;
    int          cnt;
    bit          seen;

    vecs[0] = '{10,  1'b0, 32'd10, 32'd100};
    vecs[1] = '{30,  1'b0, 32'd4,  32'd120};
    vecs[2] = '{100, 1'b0, 32'd1,  32'd100};
    vecs[3] = '{7,   1'b0, 32'd15, 32'd105};
    vecs[4] = '{50,  1'b1, 32'd2,  32'd100};
    vecs[5] = '{33,  1'b0, 32'd4,  32'd132};
    vecs[6] = '{4,   1'b1, 32'd25, 32'd100};

    bus.START = 1'b0;
    CLR = 1'b0;

    // Reset hold: counters cleared, everything else low.
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("rst_cnt_clr", 32'(bus.CNT_CLR), 32'd0);
      check("rst_outs", {27'd0, bus.SIG_EN, bus.BASE_EN, bus.BUSY, bus.DONE, 1'b0}, 32'd0);
      check("rst_sig_cnt", bus.SIG_CNT, 32'd0);
      check("rst_base_cnt", bus.BASE_CNT, 32'd0);
    end
    CLR = 1'b1;
    @(negedge CLK);
    check("rel_cnt_clr", 32'(bus.CNT_CLR), 32'd1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.BUSY || bus.DONE || bus.SIG_EN || bus.BASE_EN || !bus.CNT_CLR) cnt++;
      @(negedge CLK);
    end
    check("idle_quiet", 32'(cnt), 32'd0);

    // CLEAR timing: CNT_CLR low for exactly CLR_CYCLES cycles starting one cycle after START.
    period = 10;
    repeat (50) @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    check("clear_c1", {30'd0, bus.CNT_CLR, bus.BUSY}, 32'd1);
    @(negedge CLK);
    check("clear_c2", 32'(bus.CNT_CLR), 32'd0);
    @(negedge CLK);
    check("clear_end", 32'(bus.CNT_CLR), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      if (bus.DONE === 1'b1) seen = 1'b1;
      else @(negedge CLK);
    end
    check("clear_done", 32'(seen), 32'd1);
    check("clear_sig_cnt", bus.SIG_CNT, 32'd10);
    $display("clear_seq sig_cnt=%0d base_cnt=%0d", bus.SIG_CNT, bus.BASE_CNT);

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      run_meas(vecs[i].period, vecs[i].poke, s, b, en_cyc);
      check($sformatf("vec%0d_sig_cnt", i), s, vecs[i].exp_sig);
      check($sformatf("vec%0d_base_cnt", i), b, vecs[i].exp_base);
      check($sformatf("vec%0d_en_cycles", i), 32'(en_cyc), vecs[i].exp_base);
    end

    // Random periods against the ceil(G/P) model.
    for (int i = 0; i < 8; i++) begin
      int p;
      p = $urandom_range(4, 60);
      run_meas(p, 1'b0, s, b, en_cyc);
      check($sformatf("rnd%0d_sig_cnt", i), s, 32'(n_periods(p)));
      check($sformatf("rnd%0d_base_cnt", i), b, 32'(n_periods(p) * p));
      check($sformatf("rnd%0d_en_cycles", i), 32'(en_cyc), 32'(n_periods(p) * p));
    end
    last_s = s;
    last_b = b;

    // Reset pulse in the middle of GATE.
    period = 20;
    repeat (250) @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 500 && !seen; k++) begin
      if (bus.SIG_EN === 1'b1) seen = 1'b1;
      else @(negedge CLK);
    end
    check("midrst_gate_reached", 32'(seen), 32'd1);
    repeat (10) @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);
    CLR = 1'b1;
    check("midrst_outs", {27'd0, bus.SIG_EN, bus.BASE_EN, bus.CNT_CLR, bus.BUSY, bus.DONE}, 32'd0);
    check("midrst_sig_cnt", bus.SIG_CNT, 32'd0);
    check("midrst_base_cnt", bus.BASE_CNT, 32'd0);
    @(negedge CLK);
    check("midrst_rel_cnt_clr", 32'(bus.CNT_CLR), 32'd1);
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      if (bus.DONE || bus.BUSY || bus.SIG_EN) cnt++;
      @(negedge CLK);
    end
    check("midrst_no_done", 32'(cnt), 32'd0);
    $display("midrst sig_cnt=%0d base_cnt=%0d", bus.SIG_CNT, bus.BASE_CNT);

    // Refill the result registers so the timeout can show they are kept.
    run_meas(40, 1'b0, last_s, last_b, en_cyc);
    check("refill_sig_cnt", last_s, 32'd3);
    check("refill_base_cnt", last_b, 32'd120);

`ifdef FREQ_GATE_TIMEOUT_EN
    period = 0;
    repeat (250) @(negedge CLK);
    bus.START = 1'b1;
    cnt = 0;
    seen = 1'b0;
    for (int k = 1; k < 3000 && !seen; k++) begin
      @(negedge CLK);
      bus.START = 1'b0;
      if (bus.DONE === 1'b1) begin
        seen = 1'b1;
        cnt = k;
      end
    end
    check("tmo_done_seen", 32'(seen), 32'd1);
    check("tmo_latency", 32'(cnt), 32'(CLRC + 1 + TMO));
    check("tmo_err", 32'(bus.ERR), 32'd1);
    check("tmo_en", {30'd0, bus.SIG_EN, bus.BUSY}, 32'd0);
    check("tmo_sig_kept", bus.SIG_CNT, last_s);
    check("tmo_base_kept", bus.BASE_CNT, last_b);
    $display("timeout latency=%0d err=%0d sig_cnt=%0d base_cnt=%0d", cnt, bus.ERR, bus.SIG_CNT, bus.BASE_CNT);
    @(negedge CLK);
    check("tmo_err_holds", {30'd0, bus.ERR, bus.DONE}, 32'd2);
    period = 10;
    repeat (250) @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    check("tmo_err_cleared", 32'(bus.ERR), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      if (bus.DONE === 1'b1) seen = 1'b1;
      else @(negedge CLK);
    end
    check("tmo_after_done", 32'(seen), 32'd1);
    check("tmo_after_err", 32'(bus.ERR), 32'd0);
    check("tmo_after_sig_cnt", bus.SIG_CNT, 32'd10);
    $display("post_timeout sig_cnt=%0d base_cnt=%0d err=%0d", bus.SIG_CNT, bus.BASE_CNT, bus.ERR);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
- Gate controller for the equal-precision frequency meter.
- Sits directly upstream of the dual 32-bit counter pair (signal counter, base counter). It drives the counter clear and the two count enables, and takes the counter outputs back.
- The gate opens and closes on rising edges of the measured signal, so the signal count is always an integer number of periods.
- Latches both counts and flags completion for the host interface.

Parameters:
- GATE_CYCLES, 100000, minimum gate length in CLK cycles; must be ≥ 1.
- CLR_CYCLES, 2, length of the counter-clear pulse in CLK cycles; must be ≥ 1.
- SETTLE_CYCLES, 4, wait between gate close and result capture, covering the cross-domain settle of the signal counter.
- TIMEOUT_CYCLES, 50000000, ARM/GATE watchdog limit. Used only with FREQ_GATE_TIMEOUT_EN.

Ports:
- CLK  in  1  base clock; also clocks the base counter.
- CLR  in  1  synchronous active-low reset.
- START  in  1  one-cycle request to begin a measurement.
- SIG  in  1  measured signal, asynchronous to CLK.
- Q_IN  in  32  signal-counter value.
- QBASE_IN  in  32  base-counter value.
- CNT_CLR  out  1  active-low clear to both counters.
- SIG_EN  out  1  signal-counter enable.
- BASE_EN  out  1  base-counter enable.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when results are valid.
- SIG_CNT  out  32  latched signal count.
- BASE_CNT  out  32  latched base count.
- ERR  out  1  timeout flag; present only with FREQ_GATE_TIMEOUT_EN.

Behaviour:
- One clock (CLK). Reset is synchronous, active-low, named CLR. All outputs are registered.
- Reset values:
  - CNT_CLR=0, so the counters are held clear during reset.
  - SIG_EN=0, BASE_EN=0, BUSY=0, DONE=0.
  - SIG_CNT=0, BASE_CNT=0, ERR=0.
  - State=IDLE.
- CNT_CLR returns to 1 on the first cycle after reset release.
- SIG input path: 2-FF synchronizer, then a third FF for edge detection. sig_rise = sync & ~prev, one CLK cycle wide. Latency from SIG edge to sig_rise is 2–3 cycles.
- States and transitions:
  - IDLE: START=1 → CLEAR. START is ignored in every other state.
  - CLEAR: CNT_CLR=0 for exactly CLR_CYCLES cycles, then → ARM.
  - ARM: wait for sig_rise. On sig_rise → GATE, with gate_cnt=1 and SIG_EN=BASE_EN=1 from the next cycle.
  - GATE: gate_cnt increments each cycle and saturates at GATE_CYCLES. When gate_cnt ≥ GATE_CYCLES and sig_rise are true in the same cycle → SETTLE, and SIG_EN/BASE_EN drop the next cycle.
    - A sig_rise with gate_cnt < GATE_CYCLES does not close the gate.
    - Enables are high for exactly ceil(GATE_CYCLES/P)·P cycles for a stable period of P cycles.
  - SETTLE: SETTLE_CYCLES cycles, then → LATCH.
  - LATCH: SIG_CNT←Q_IN, BASE_CNT←QBASE_IN; DONE=1 for this one cycle; → IDLE.
- BUSY=1 in CLEAR, ARM, GATE, SETTLE and LATCH.
- SIG_CNT and BASE_CNT hold their values until the next LATCH.
- SIG_EN and BASE_EN always change together.
- CLR low mid-operation: immediate return to reset values on the next edge. No DONE is produced and latched results are zeroed.

Optional Feature:
- Macro FREQ_GATE_TIMEOUT_EN.
- When defined:
  - A 32-bit watchdog counts cycles spent in ARM+GATE.
  - Reaching TIMEOUT_CYCLES → IDLE, enables dropped, SIG_CNT/BASE_CNT left unchanged, DONE pulses, ERR=1.
  - ERR clears on the next START.
- When undefined: no watchdog and no ERR port. ARM/GATE wait indefinitely.

Decomposition:
- Shared package:
  - State enum (IDLE, CLEAR, ARM, GATE, SETTLE, LATCH).
  - Counter width constant CNT_W=32.
- One sub-module: sig_edge_sync (2-FF synchronizer plus rising-edge pulse). It is reusable for other asynchronous inputs.

Test Plan:
- Reset/idle: CLR low for 5 cycles, then high, with no START → CNT_CLR=0 during reset, then 1; all other outputs 0; BUSY stays 0.
- Nominal, period divides GATE_CYCLES: GATE_CYCLES=100, SIG period 10 CLK cycles, bench counter model, START → enables high 100 cycles; SIG_CNT=10, BASE_CNT=100; one DONE pulse; BUSY falls with DONE.
- Nominal, non-dividing period: GATE_CYCLES=100, SIG period 30 → enables high 120 cycles; SIG_CNT=4, BASE_CNT=120.
- CLEAR timing: CLR_CYCLES=2, START → CNT_CLR low for exactly 2 cycles starting 1 cycle after START. A second START during GATE causes no state change.
- Reset mid-GATE: CLR low for 1 cycle while in GATE → next cycle SIG_EN=BASE_EN=0, CNT_CLR=0, state IDLE, SIG_CNT=BASE_CNT=0, no DONE.
- Timeout (FREQ_GATE_TIMEOUT_EN, TIMEOUT_CYCLES=1000, SIG held low): START → after 1000 cycles in ARM, DONE pulses with ERR=1, previous SIG_CNT/BASE_CNT retained; next START clears ERR.
